// File: rtl/aud_pkg.sv
// aud_pkg: shared types and widths for the audio record/playback controller.
// Imported by the sequencer and its SRAM port mux.
package aud_pkg;

   localparam int AUD_ADDR_W = 20;
   localparam int AUD_DATA_W = 16;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REC        = 3'd1,
      S_REC_PAUSE  = 3'd2,
      S_PLAY       = 3'd3,
      S_PLAY_PAUSE = 3'd4
   } ctrl_state_t;

endpackage

// File: rtl/aud_sram_mux.sv
// aud_sram_mux: selects who owns the single SRAM port.
// Recorder owns it in REC/REC_PAUSE; the player owns it otherwise.
module aud_sram_mux
   import aud_pkg::*;
#(
   parameter int ADDR_W = AUD_ADDR_W,
   parameter int DATA_W = AUD_DATA_W
) (
   input  ctrl_state_t       state,
   input  logic [ADDR_W-1:0] rec_addr,
   input  logic [DATA_W-1:0] rec_data,
   input  logic [ADDR_W-1:0] play_addr,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_we_n
);

   // Port select; only an active (unpaused) recording writes.
   always_comb begin
      sram_addr  = play_addr;
      sram_wdata = '0;
      sram_we_n  = 1'b1;
      unique case (1'b1)
         (state == S_REC): begin
            sram_addr  = rec_addr;
            sram_wdata = rec_data;
            sram_we_n  = 1'b0;
         end
         (state == S_REC_PAUSE): begin
            sram_addr  = rec_addr;
            sram_wdata = rec_data;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/aud_mode_ctrl.sv
// aud_mode_ctrl: record/playback sequencer. Turns key pulses into
// recorder/player control, latches the recording end address.
module aud_mode_ctrl
   import aud_pkg::*;
#(
   parameter int                ADDR_W   = AUD_ADDR_W,
   parameter int                DATA_W   = AUD_DATA_W,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [DATA_W-1:0] i_rec_data,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wdata,
   output logic              o_sram_we_n,
   output logic [2:0]        o_state
);

   ctrl_state_t state;

   // Sequencer: key priority stop > pause > rec > play; pulses last one cycle.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
         o_end_addr   <= '0;
      end else begin
         o_rec_start  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_stop  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_key_stop || i_key_pause) begin
                  state <= S_IDLE;
               end else if (i_key_rec) begin
                  state       <= S_REC;
                  o_rec_start <= 1'b1;
               end else if (i_key_play && (o_end_addr != '0)) begin
                  state        <= S_PLAY;
                  o_play_start <= 1'b1;
               end
            end
            S_REC: begin
               if (i_key_stop || (i_rec_addr == MAX_ADDR)) begin
                  state      <= S_IDLE;
                  o_rec_stop <= 1'b1;
                  o_end_addr <= i_rec_addr;
               end else if (i_key_pause) begin
                  state       <= S_REC_PAUSE;
                  o_rec_pause <= 1'b1;
               end
            end
            S_REC_PAUSE: begin
               if (i_key_stop) begin
                  state       <= S_IDLE;
                  o_rec_pause <= 1'b0;
                  o_rec_stop  <= 1'b1;
                  o_end_addr  <= i_rec_addr;
               end else if (i_key_pause) begin
                  state       <= S_REC;
                  o_rec_pause <= 1'b0;
               end
            end
            S_PLAY: begin
               if (i_key_stop || (i_play_addr >= o_end_addr)) begin
                  state       <= S_IDLE;
                  o_play_stop <= 1'b1;
               end else if (i_key_pause) begin
                  state        <= S_PLAY_PAUSE;
                  o_play_pause <= 1'b1;
               end
            end
            S_PLAY_PAUSE: begin
               if (i_key_stop) begin
                  state        <= S_IDLE;
                  o_play_pause <= 1'b0;
                  o_play_stop  <= 1'b1;
               end else if (i_key_pause) begin
                  state        <= S_PLAY;
                  o_play_pause <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               o_rec_pause  <= 1'b0;
               o_play_pause <= 1'b0;
            end
         endcase
      end
   end

   assign o_state = state;

   aud_sram_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .state      (state),
      .rec_addr   (i_rec_addr),
      .rec_data   (i_rec_data),
      .play_addr  (i_play_addr),
      .sram_addr  (o_sram_addr),
      .sram_wdata (o_sram_wdata),
      .sram_we_n  (o_sram_we_n)
   );

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// tb_aud_mode_ctrl: scoreboard bench for the record/playback sequencer.
// Expected snapshots are queued with each stimulus and popped after the edge.
module tb_aud_mode_ctrl;

   typedef struct packed {
      logic [2:0]  st;
      logic        rs;
      logic        rp;
      logic        rt;
      logic        ps;
      logic        pp;
      logic        pt;
      logic [19:0] ea;
      logic        we;
      logic [19:0] sa;
      logic [15:0] wd;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        k_rec = 1'b0;
   logic        k_play = 1'b0;
   logic        k_pause = 1'b0;
   logic        k_stop = 1'b0;
   logic [19:0] rec_addr = '0;
   logic [15:0] rec_data = '0;
   logic [19:0] play_addr = '0;
   logic        rec_start, rec_pause, rec_stop;
   logic        play_start, play_pause, play_stop;
   logic [19:0] end_addr, sram_addr;
   logic [15:0] sram_wdata;
   logic        sram_we_n;
   logic [2:0]  state;

   int    total = 0;
   int    bad = 0;
   snap_t exp_q[$];
   snap_t e;
   snap_t o;

   always #5 clk = ~clk;

   aud_mode_ctrl dut (
      .i_bclk       (clk),
      .i_rst_n      (rst_n),
      .i_key_rec    (k_rec),
      .i_key_play   (k_play),
      .i_key_pause  (k_pause),
      .i_key_stop   (k_stop),
      .i_rec_addr   (rec_addr),
      .i_rec_data   (rec_data),
      .i_play_addr  (play_addr),
      .o_rec_start  (rec_start),
      .o_rec_pause  (rec_pause),
      .o_rec_stop   (rec_stop),
      .o_play_start (play_start),
      .o_play_pause (play_pause),
      .o_play_stop  (play_stop),
      .o_end_addr   (end_addr),
      .o_sram_addr  (sram_addr),
      .o_sram_wdata (sram_wdata),
      .o_sram_we_n  (sram_we_n),
      .o_state      (state)
   );

   function automatic snap_t snap();
      snap_t s;
      s.st = state;
      s.rs = rec_start;
      s.rp = rec_pause;
      s.rt = rec_stop;
      s.ps = play_start;
      s.pp = play_pause;
      s.pt = play_stop;
      s.ea = end_addr;
      s.we = sram_we_n;
      s.sa = sram_addr;
      s.wd = sram_wdata;
      return s;
   endfunction

   function automatic snap_t mk(input logic [2:0] st,
                                input logic [5:0] pl,
                                input logic [19:0] ea,
                                input logic we,
                                input logic [19:0] sa,
                                input logic [15:0] wd);
      snap_t s;
      s.st = st;
      {s.rs, s.rp, s.rt, s.ps, s.pp, s.pt} = pl;
      s.ea = ea;
      s.we = we;
      s.sa = sa;
      s.wd = wd;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      k_rec = 0;
      k_play = 0;
      k_pause = 0;
      k_stop = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      play_addr = 20'h00042;
      #3;
      exp_q.push_back(mk(0, 6'b0, 0, 1, 20'h00042, 0));
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL reset got=%h want=%h", o, e);
      end
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_rec_start();
      rec_addr = 20'h00010;
      rec_data = 16'hBEEF;
      k_rec = 1;
      exp_q.push_back(mk(1, 6'b100000, 0, 0, 20'h00010, 16'hBEEF));
      exp_q.push_back(mk(1, 6'b000000, 0, 0, 20'h00010, 16'hBEEF));
      for (int i = 0; i < 2; i++) begin
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rec_start[%0d] got=%h want=%h", i, o, e);
         end
      end
   endtask

   task automatic test_rec_stop();
      rec_addr = 20'h00123;
      play_addr = 20'h00000;
      k_stop = 1;
      exp_q.push_back(mk(0, 6'b001000, 20'h00123, 1, 0, 0));
      exp_q.push_back(mk(0, 6'b000000, 20'h00123, 1, 0, 0));
      for (int i = 0; i < 2; i++) begin
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rec_stop[%0d] got=%h want=%h", i, o, e);
         end
      end
   endtask

   task automatic test_play_ramp();
      logic [19:0] a;
      k_play = 1;
      exp_q.push_back(mk(3, 6'b000100, 20'h00123, 1, 0, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL play_start got=%h want=%h", o, e);
      end
      for (int i = 0; i < 4; i++) begin
         a = 20'h00120 + 20'(i);
         play_addr = a;
         if (a >= 20'h00123)
            exp_q.push_back(mk(0, 6'b000001, 20'h00123, 1, a, 0));
         else
            exp_q.push_back(mk(3, 6'b000000, 20'h00123, 1, a, 0));
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL play_ramp[%0d] got=%h want=%h", i, o, e);
         end
      end
      exp_q.push_back(mk(0, 6'b000000, 20'h00123, 1, 20'h00123, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL play_end_clr got=%h want=%h", o, e);
      end
   endtask

   task automatic test_play_pause();
      snap_t steps[5];
      play_addr = 20'h00010;
      steps[0] = mk(3, 6'b000100, 20'h00123, 1, 20'h00010, 0);
      steps[1] = mk(4, 6'b000010, 20'h00123, 1, 20'h00010, 0);
      steps[2] = mk(4, 6'b000010, 20'h00123, 1, 20'h00020, 0);
      steps[3] = mk(3, 6'b000000, 20'h00123, 1, 20'h00020, 0);
      steps[4] = mk(0, 6'b000001, 20'h00123, 1, 20'h00020, 0);
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: k_play = 1;
            1: k_pause = 1;
            2: play_addr = 20'h00020;
            3: k_pause = 1;
            default: k_stop = 1;
         endcase
         exp_q.push_back(steps[i]);
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL play_pause[%0d] got=%h want=%h", i, o, e);
         end
      end
   endtask

   task automatic test_rec_pause();
      snap_t steps[4];
      rec_addr = 20'h00200;
      rec_data = 16'h1234;
      play_addr = 20'h00007;
      steps[0] = mk(1, 6'b100000, 20'h00123, 0, 20'h00200, 16'h1234);
      steps[1] = mk(2, 6'b010000, 20'h00123, 1, 20'h00200, 16'h1234);
      steps[2] = mk(1, 6'b000000, 20'h00123, 0, 20'h00200, 16'h1234);
      steps[3] = mk(2, 6'b010000, 20'h00123, 1, 20'h00200, 16'h1234);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) k_rec = 1;
         else k_pause = 1;
         exp_q.push_back(steps[i]);
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL rec_pause[%0d] got=%h want=%h", i, o, e);
         end
      end
      rec_addr = 20'h00345;
      k_stop = 1;
      exp_q.push_back(mk(0, 6'b001000, 20'h00345, 1, 20'h00007, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL rec_pause_stop got=%h want=%h", o, e);
      end
   endtask

   task automatic test_idle_ignore();
      rst_n = 0;
      #2;
      rst_n = 1;
      play_addr = 20'h00000;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: k_play = 1;
            1: begin k_rec = 1; k_stop = 1; end
            default: begin k_rec = 1; k_pause = 1; end
         endcase
         exp_q.push_back(mk(0, 6'b0, 0, 1, 0, 0));
         tick();
         o = snap();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL idle_ignore[%0d] got=%h want=%h", i, o, e);
         end
      end
   endtask

   task automatic test_max_and_reset();
      rec_addr = 20'h00005;
      rec_data = 16'h0F0F;
      play_addr = 20'h00001;
      k_rec = 1;
      exp_q.push_back(mk(1, 6'b100000, 0, 0, 20'h00005, 16'h0F0F));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL max_rec got=%h want=%h", o, e);
      end
      rec_addr = 20'hFFFFF;
      exp_q.push_back(mk(0, 6'b001000, 20'hFFFFF, 1, 20'h00001, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL max_stop got=%h want=%h", o, e);
      end
      k_play = 1;
      exp_q.push_back(mk(3, 6'b000100, 20'hFFFFF, 1, 20'h00001, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL max_play got=%h want=%h", o, e);
      end
      #2;
      rst_n = 0;
      #1;
      exp_q.push_back(mk(0, 6'b0, 0, 1, 20'h00001, 0));
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL mid_play_reset got=%h want=%h", o, e);
      end
      tick();
      rst_n = 1;
      exp_q.push_back(mk(0, 6'b0, 0, 1, 20'h00001, 0));
      tick();
      o = snap();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL post_reset got=%h want=%h", o, e);
      end
   endtask

   initial begin
      test_reset();
      test_rec_start();
      test_rec_stop();
      test_play_ramp();
      test_play_pause();
      test_rec_pause();
      test_idle_ignore();
      test_max_and_reset();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
